// File: rtl/dice_led_scanner.sv
// Scans NUM_DICE dice faces over one shared 3x3 LED bus with per-die select,
// dead time between slots, PWM brightness and frame-aligned value updates.
module dice_led_scanner #(
  parameter int NUM_DICE    = 2,
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 2,
  parameter int PWM_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*NUM_DICE-1:0] dice_values_i,
  input  logic                  load_i,
  input  logic                  blank_i,
  input  logic [PWM_BITS-1:0]   brightness_i,
  output logic [8:0]            leds_o,
  output logic [NUM_DICE-1:0]   die_sel_o,
  output logic                  frame_start_o
);

  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SLOT_W = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DICE - 1);

  logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [3*NUM_DICE-1:0] shadow_q, shadow_d;
  logic [3*NUM_DICE-1:0] active_q, active_d;
  logic [8:0]            leds_q, leds_d;
  logic [NUM_DICE-1:0]   die_sel_q, die_sel_d;
  logic                  frame_start_q, frame_start_d;

  logic                  slot_wrap, frame_end, in_dead, show;
  logic [2:0]            cur_val;
  logic [NUM_DICE-1:0]   one_hot;

  function automatic logic [8:0] pip_pattern(input logic [2:0] v);
    case (v)
      3'd0:    return 9'b000000000;
      3'd1:    return 9'b000010000;
      3'd2:    return 9'b100000001;
      3'd3:    return 9'b100010001;
      3'd4:    return 9'b101000101;
      3'd5:    return 9'b101010101;
      3'd6:    return 9'b101101101;
      default: return 9'b111101111;
    endcase
  endfunction

  if (DEAD_CYCLES > 0) begin : g_dead
    assign in_dead = slot_cnt_q < CNT_W'(DEAD_CYCLES);
  end else begin : g_no_dead
    assign in_dead = 1'b0;
  end

  always_comb begin
    // NOTE: every bit gets a default before the indexed write, so no latch is inferred.
    one_hot         = '0;
    one_hot[slot_q] = 1'b1;
  end

  always_comb begin
    slot_wrap  = (slot_cnt_q == CNT_LAST);
    frame_end  = slot_wrap && (slot_q == SLOT_LAST);
    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
    pwm_cnt_d  = slot_wrap ? '0 : pwm_cnt_q + PWM_BITS'(1);
    slot_d     = slot_q;
    if (slot_wrap) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);

    // Feeding active from shadow_d lets a load on the frame's last cycle bypass.
    shadow_d = load_i ? dice_values_i : shadow_q;
    active_d = frame_end ? shadow_d : active_q;

    cur_val       = active_q[3*int'(slot_q) +: 3];
    show          = !blank_i && !in_dead;
    die_sel_d     = show ? one_hot : '0;
    leds_d        = (show && (pwm_cnt_q < brightness_i)) ? pip_pattern(cur_val) : '0;
    frame_start_d = (slot_q == '0) && (slot_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q    <= '0;
      slot_q        <= '0;
      pwm_cnt_q     <= '0;
      // NOTE: value storage is reset too, so a reset also discards a pending load.
      shadow_q      <= '0;
      active_q      <= '0;
      leds_q        <= '0;
      die_sel_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      slot_cnt_q    <= slot_cnt_d;
      slot_q        <= slot_d;
      pwm_cnt_q     <= pwm_cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      leds_q        <= leds_d;
      die_sel_q     <= die_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign leds_o        = leds_q;
  assign die_sel_o     = die_sel_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_dice_led_scanner.sv
// Drives two scanner configurations with shared stimulus and compares both
// against a time-based model of the scan, every cycle.
module tb_dice_led_scanner;

  localparam int PB = 4;
  localparam int ND_A = 2, SD_A = 8,  DC_A = 2;
  localparam int ND_B = 3, SD_B = 40, DC_B = 0;
  localparam int M_ND [2] = '{ND_A, ND_B};
  localparam int M_SD [2] = '{SD_A, SD_B};
  localparam int M_DC [2] = '{DC_A, DC_B};
  localparam logic [8:0] PAT [8] = '{9'b000000000, 9'b000010000, 9'b100000001,
                                     9'b100010001, 9'b101000101, 9'b101010101,
                                     9'b101101101, 9'b111101111};

  logic clk = 1'b0;
  logic rst = 1'b1, load = 1'b0, blank = 1'b0;
  logic [8:0] dv = '0;
  logic [PB-1:0] bright = '1;
  logic [8:0] leds_a, leds_b;
  logic [ND_A-1:0] sel_a;
  logic [ND_B-1:0] sel_b;
  logic fs_a, fs_b;

  int checks = 0, failures = 0;

  int t [2];
  int sh [2][3];
  int ac [2][3];
  logic [8:0] exp_leds [2];
  int exp_sel [2];
  logic exp_fs [2];

  always #5 clk = ~clk;

  dice_led_scanner #(.NUM_DICE(ND_A), .SCAN_DIV(SD_A), .DEAD_CYCLES(DC_A), .PWM_BITS(PB)) dut_a (
    .clk(clk), .rst(rst), .dice_values_i(dv[3*ND_A-1:0]), .load_i(load), .blank_i(blank),
    .brightness_i(bright), .leds_o(leds_a), .die_sel_o(sel_a), .frame_start_o(fs_a));

  dice_led_scanner #(.NUM_DICE(ND_B), .SCAN_DIV(SD_B), .DEAD_CYCLES(DC_B), .PWM_BITS(PB)) dut_b (
    .clk(clk), .rst(rst), .dice_values_i(dv[3*ND_B-1:0]), .load_i(load), .blank_i(blank),
    .brightness_i(bright), .leds_o(leds_b), .die_sel_o(sel_b), .frame_start_o(fs_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position in the scan is derived from cycles elapsed since reset release.
  task automatic model_cycle();
    for (int k = 0; k < 2; k++) begin
      int nd, sd, period, cnt, slot;
      bit show;
      nd = M_ND[k]; sd = M_SD[k]; period = nd * sd;
      if (rst) begin
        exp_leds[k] = '0; exp_sel[k] = 0; exp_fs[k] = 1'b0; t[k] = 0;
        for (int i = 0; i < 3; i++) begin sh[k][i] = 0; ac[k][i] = 0; end
      end else begin
        cnt  = t[k] % sd;
        slot = (t[k] / sd) % nd;
        show = !blank && (cnt >= M_DC[k]);
        exp_fs[k]   = (t[k] % period) == 0;
        exp_sel[k]  = show ? (1 << slot) : 0;
        exp_leds[k] = (show && (cnt % (1 << PB)) < int'(bright)) ? PAT[ac[k][slot]] : 9'd0;
        if (load) for (int i = 0; i < nd; i++) sh[k][i] = int'(dv[3*i +: 3]);
        if ((t[k] % period) == period - 1) for (int i = 0; i < nd; i++) ac[k][i] = sh[k][i];
        t[k]++;
      end
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    check("leds_a", 32'(leds_a), 32'(exp_leds[0]));
    check("sel_a", 32'(sel_a), exp_sel[0]);
    check("fs_a", 32'(fs_a), 32'(exp_fs[0]));
    check("leds_b", 32'(leds_b), 32'(exp_leds[1]));
    check("sel_b", 32'(sel_b), exp_sel[1]);
    check("fs_b", 32'(fs_b), 32'(exp_fs[1]));
  endtask

  initial begin
    rst = 1'b1; bright = '1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("lit_frame_start", 32'(fs_a), 32'd1);
    step(); step();
    check("lit_sel_slot0", 32'(sel_a), 32'b01);
    repeat (8) step();
    check("lit_sel_slot1", 32'(sel_a), 32'b10);

    dv = {3'd4, 3'd7, 3'd2}; load = 1'b1; step(); load = 1'b0;
    repeat (4) begin dv = 9'($urandom); step(); end
    repeat (3) step();
    check("lit_die0_val2", 32'(leds_a), 32'b100000001);
    check("lit_die0_sel", 32'(sel_a), 32'b01);
    repeat (8) step();
    check("lit_die1_val7", 32'(leds_a), 32'b111101111);

    repeat (4) step();
    dv = {3'd0, 3'd5, 3'd6}; load = 1'b1; step(); load = 1'b0;
    repeat (3) step();
    check("lit_bypass_val6", 32'(leds_a), 32'b101101101);

    blank = 1'b1; step();
    check("lit_blank_sel", 32'(sel_a), 32'd0);
    check("lit_blank_leds", 32'(leds_a), 32'd0);
    step(); step(); blank = 1'b0; step();
    check("lit_unblank_sel", 32'(sel_a), 32'b01);

    dv = 9'($urandom); load = 1'b1; step(); load = 1'b0; step();
    dv = {3'd2, 3'd3, 3'd1}; load = 1'b1; step(); load = 1'b0;
    repeat (9) step();
    check("lit_second_load", 32'(leds_a), 32'b000010000);

    bright = 4'd4;
    repeat (200) begin dv = 9'($urandom); load = ($urandom % 5) == 0; step(); end
    bright = 4'd0;
    repeat (200) begin dv = 9'($urandom); load = ($urandom % 5) == 0; step(); end
    load = 1'b0; bright = '1;

    rst = 1'b1; step();
    check("lit_rst_leds", 32'(leds_a), 32'd0);
    check("lit_rst_sel", 32'(sel_a), 32'd0);
    rst = 1'b0; step();
    check("lit_rst_restart", 32'(fs_a), 32'd1);

    for (int v = 0; v < 8; v++) begin
      dv = {3'(7 - v), 3'(v), 3'(v)}; load = 1'b1; step(); load = 1'b0;
      repeat (2 * ND_B * SD_B) step();
    end

    repeat (3000) begin
      rst   = ($urandom % 300) == 0;
      load  = ($urandom % 6) == 0;
      blank = ($urandom % 20) == 0;
      if (($urandom % 50) == 0) bright = PB'($urandom);
      dv = 9'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dice_led_scanner.md
# dice_led_scanner

Time-multiplexed LED driver for a bank of NUM_DICE dice faces sharing one 3x3 LED matrix bus. Latches per-die values (0-7), maps each to its pip pattern and scans the dice one at a time with per-die select, anti-ghosting dead time and PWM brightness. Sits between the dice value logic and the padframe LED/common-select outputs, with tear-free updates at frame boundaries.

## Interface
- NUM_DICE, 2, number of dice scanned; >= 1
- SCAN_DIV, 1000, clock cycles per die slot; > DEAD_CYCLES + 1
- DEAD_CYCLES, 2, cycles at the start of each slot with all outputs off; >= 0
- PWM_BITS, 4, brightness resolution; >= 1
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- dice_values  input  3*NUM_DICE  die i value at [3i+2:3i]
- load  input  1  strobe; capture dice_values into shadow register
- blank  input  1  force leds and die_sel to 0; counters keep running
- brightness  input  PWM_BITS  LED on-duty, brightness/2^PWM_BITS
- leds  output  9  {L11,L21,L31,L12,L22,L32,L13,L23,L33}, leds[8]=L11 … leds[0]=L33
- die_sel  output  NUM_DICE  one-hot select of the die being driven
- frame_start  output  1  one-cycle pulse at the first output cycle of slot 0

## Operation
- Pattern map (active-high leds bits 8..0):
  - 0: 000000000
  - 1: 000010000
  - 2: 100000001
  - 3: 100010001
  - 4: 101000101
  - 5: 101010101
  - 6: 101101101
  - 7: 111101111
- Registers:
  - shadow[NUM_DICE]: written with dice_values on every cycle load=1; last load wins.
  - active[NUM_DICE]: displayed values.
  - slot (0..NUM_DICE-1), slot_cnt (0..SCAN_DIV-1), pwm_cnt (PWM_BITS, wraps).
- Counting:
  - slot_cnt increments every cycle.
  - At SCAN_DIV-1, slot_cnt goes to 0 and slot increments, wrapping NUM_DICE-1 -> 0.
  - pwm_cnt goes to 0 whenever slot_cnt is 0, otherwise increments mod 2^PWM_BITS.
- Frame update:
  - On the last cycle of a frame (slot=NUM_DICE-1, slot_cnt=SCAN_DIV-1), active <= shadow.
  - If load=1 in that same cycle, active <= dice_values (bypass), and shadow is also updated.
- Output decision per cycle, evaluated on the counter state:
  - If rst, blank, or slot_cnt < DEAD_CYCLES: leds=0, die_sel=0.
  - Otherwise: die_sel = 1<<slot; leds = pattern(active[slot]) when pwm_cnt < brightness, else leds = 0.
- Brightness limits: brightness=0 keeps the LEDs always off. The maximum duty is (2^PWM_BITS-1)/2^PWM_BITS.
- die_sel stays asserted during PWM-off cycles; only the dead time and blank deassert it.
- NUM_DICE=1: die_sel is 1 outside the dead time.

## Timing
- All outputs are registered. Each output reflects the counter, active and blank state of the previous cycle (1-cycle latency).
- Reset values:
  - leds=0, die_sel=0, frame_start=0.
  - shadow, active, slot, slot_cnt and pwm_cnt all 0.
- After reset release:
  - The first cycle with rst=0 has slot=0, slot_cnt=0.
  - frame_start pulses on the next cycle and then every NUM_DICE*SCAN_DIV cycles.
  - The first frame displays value 0 for all dice; a load during it appears from frame 2.
- Load to display latency: a load takes effect at the next frame boundary, worst case NUM_DICE*SCAN_DIV+1 cycles.
- Mid-frame dice_values changes without load have no effect.
- blank:
  - Asserted in cycle k forces zero outputs from k+1.
  - Deasserted in cycle k resumes the normal pattern from k+1.
  - Scan phase is unaffected.
- rst mid-frame: takes effect on the next edge. It clears all state, including pending shadow contents.
- Out-of-range widths are not possible; all 8 values are legal.

## Test plan
- Reset, NUM_DICE=2, SCAN_DIV=8, DEAD_CYCLES=2, brightness=all ones, no load -> leds=0 always; die_sel 00 for 2 cycles, then 01 for 6, then 00 for 2, then 10 for 6; frame_start period 16.
- Load dice_values={3'd7,3'd2} mid-frame 1 -> frame 1 unchanged. From frame 2: slot 0 leds=100000001 with die_sel=01; slot 1 leds=111101111 with die_sel=10.
- Load coinciding with the last frame cycle with value {5,6} -> the next slot 0 shows 101101101 (bypass). Two loads in one frame -> only the second is displayed.
- brightness=4, PWM_BITS=4, SCAN_DIV=40 -> within each slot after dead time, leds nonzero exactly when pwm_cnt<4. brightness=0 -> leds never nonzero.
- Sweep all values 0-7 on die 0 -> leds match the pattern map exactly.
- blank pulse for 3 cycles and rst asserted mid-slot -> outputs 0 one cycle later with phase unchanged (blank); rst returns all outputs and state to 0 and restarts the scan at slot 0.
